// File: rtl/uart_pkg.sv
// Shared definitions for the UART word receiver: FSM encoding, bit-count width and
// bit-timer width helper.
package uart_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StData,
      StStop
   } rx_state_e;

   localparam int unsigned BitCntW = 3;

   function automatic int unsigned timer_width(input int unsigned clks_per_bit);
      return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
   endfunction

endpackage

// File: rtl/uart_word_rx_if.sv
// Word handshake between the UART word receiver (master) and its downstream consumer (slave).
interface uart_word_rx_if;

   logic [31:0] o_data;
   logic [31:0] o_addr;
   logic        o_valid;
   logic        i_ready;

   modport master (output o_data, output o_addr, output o_valid, input i_ready);
   modport slave  (input o_data, input o_addr, input o_valid, output i_ready);

endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchroniser, start/data/stop FSM and LSB-first shifter.
// Define UART_WORD_RX_FRAME_CHECK_EN to check stop bits and wait out line breaks.
module uart_rx_byte
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 50
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       rxd_i,
   output logic       byte_vld_o,
   output logic [7:0] byte_o,
   output logic       frame_err_o
);

   localparam int unsigned       TimerW   = timer_width(CLKS_PER_BIT);
   localparam logic [TimerW-1:0] HalfLast = TimerW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TimerW-1:0] BitLast  = TimerW'(CLKS_PER_BIT - 1);

   rx_state_e          state_q, state_d;
   logic               sync1_q, sync2_q;
   logic [TimerW-1:0]  timer_q, timer_d;
   logic [BitCntW-1:0] bit_q, bit_d;
   logic [7:0]         shift_q, shift_d;
   logic               vld_q, vld_d;
   logic               ferr_q, ferr_d;
`ifdef UART_WORD_RX_FRAME_CHECK_EN
   logic               brk_q, brk_d;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         state_q <= StIdle;
         timer_q <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         vld_q   <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef UART_WORD_RX_FRAME_CHECK_EN
         brk_q   <= 1'b0;
`endif
      end else begin
         sync1_q <= rxd_i;
         sync2_q <= sync1_q;
         state_q <= state_d;
         timer_q <= timer_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         vld_q   <= vld_d;
         ferr_q  <= ferr_d;
`ifdef UART_WORD_RX_FRAME_CHECK_EN
         brk_q   <= brk_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      vld_d   = 1'b0;
      ferr_d  = 1'b0;
`ifdef UART_WORD_RX_FRAME_CHECK_EN
      brk_d   = brk_q;
`endif
      unique case (state_q)
         StIdle: begin
            timer_d = '0;
            bit_d   = '0;
            if (!sync2_q) state_d = StStart;
         end
         StStart: begin
            if (timer_q == HalfLast) begin
               timer_d = '0;
               state_d = sync2_q ? StIdle : StData;
            end
         end
         StData: begin
            if (timer_q == BitLast) begin
               timer_d = '0;
               shift_d = {sync2_q, shift_q[7:1]};
               if (&bit_q) state_d = StStop;
               else        bit_d   = bit_q + 1'b1;
            end
         end
         StStop: begin
`ifdef UART_WORD_RX_FRAME_CHECK_EN
            // After a bad stop bit, hold here until the line idles so a break is not a start.
            if (brk_q) begin
               timer_d = timer_q;
               if (sync2_q) begin
                  brk_d   = 1'b0;
                  state_d = StIdle;
               end
            end else if (timer_q == BitLast) begin
               if (sync2_q) begin
                  vld_d   = 1'b1;
                  state_d = StIdle;
               end else begin
                  ferr_d  = 1'b1;
                  brk_d   = 1'b1;
               end
            end
`else
            if (timer_q == BitLast) begin
               vld_d   = 1'b1;
               state_d = StIdle;
            end
`endif
         end
         default: state_d = StIdle;
      endcase
   end

   assign byte_vld_o  = vld_q;
   assign byte_o      = shift_q;
   assign frame_err_o = ferr_q;

endmodule

// File: rtl/uart_word_rx.sv
// UART-to-word receive stage: packs four bytes little-endian into an addressed word with
// valid/ready output and sticky error flags. Frame checking: UART_WORD_RX_FRAME_CHECK_EN.
module uart_word_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 50,
   parameter int unsigned ADDR_STEP    = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  w_rxd,
   uart_word_rx_if.master        word_if,
   output logic                  o_frame_err,
   output logic                  o_overrun
);

   localparam logic [1:0] LaneLast = 2'd3;

   logic        byte_vld;
   logic [7:0]  rx_byte;
   logic        frame_err;
   logic        xfer;

   logic [1:0]  lane_q, lane_d;
   logic [23:0] part_q, part_d;
   logic [31:0] data_q, data_d;
   logic [31:0] addr_q, addr_d;
   logic        valid_q, valid_d;
   logic        ferr_q, ferr_d;
   logic        ovr_q, ovr_d;

   uart_rx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx_byte (
      .clk_i      (CLK),
      .rst_i      (RST),
      .rxd_i      (w_rxd),
      .byte_vld_o (byte_vld),
      .byte_o     (rx_byte),
      .frame_err_o(frame_err)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         lane_q  <= '0;
         part_q  <= '0;
         data_q  <= '0;
         addr_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         lane_q  <= lane_d;
         part_q  <= part_d;
         data_q  <= data_d;
         addr_q  <= addr_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      lane_d  = lane_q;
      part_d  = part_q;
      data_d  = data_q;
      addr_d  = addr_q;
      valid_d = valid_q;
      ferr_d  = ferr_q | frame_err;
      ovr_d   = ovr_q;
      xfer    = valid_q & word_if.i_ready;

      if (xfer) begin
         addr_d  = addr_q + ADDR_STEP;
         valid_d = 1'b0;
      end

      if (byte_vld) begin
         lane_d = lane_q + 1'b1;
         if (lane_q == LaneLast) begin
            // A word completing while the holding register is still occupied is dropped whole.
            if (!valid_q || xfer) begin
               data_d  = {rx_byte, part_q};
               valid_d = 1'b1;
            end else begin
               ovr_d   = 1'b1;
            end
         end else begin
            case (lane_q)
               2'd0:    part_d[7:0]   = rx_byte;
               2'd1:    part_d[15:8]  = rx_byte;
               default: part_d[23:16] = rx_byte;
            endcase
         end
      end
   end

   assign word_if.o_data  = data_q;
   assign word_if.o_addr  = addr_q;
   assign word_if.o_valid = valid_q;
   assign o_frame_err     = ferr_q;
   assign o_overrun       = ovr_q;

endmodule
